// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the execute stage and its ALU:
//   alu_op_t            ALU operation encoding carried in the ID/EX register
//   FWD_REG/WB/MEM      operand forward-select codes (2'b11 also selects the register value)
//   ST_WORD             store-type code for a word store (funct3 encoding)
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASSB  = 4'd10,
    ALU_UNUSED = 4'd11
  } alu_op_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] ST_WORD = 3'b010;

endpackage

// File: rtl/execute_stage_alu.sv
// alu
// Purely combinational ALU.
//   a_i, b_i   operands (DATA_WIDTH)
//   op_i       operation (alu_op_t)
//   result_o   result (DATA_WIDTH); arithmetic wraps, no overflow flag.
//              ALU_UNUSED and codes outside the enum give 0.
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  alu_op_t               op_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  // Shift amount is always the low five bits of b, as in RV32.
  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLT:   result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Pipeline execute stage: operand forwarding, ALU, branch target, EX/MEM register.
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_stall_m                hold the EX/MEM register
//   i_*_e                    ID/EX pipeline register fields
//   i_forward_a_e/_b_e       forward selects (00 reg, 01 WB, 10 MEM, 11 reg)
//   i_result_w               writeback-stage result
//   o_zero_e, o_pctarget_e   combinational zero flag / branch target to the front end
//   o_*_m                    EX/MEM pipeline register outputs
module execute_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_WIDTH   = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall_m,
  input  logic                  i_regwrite_e,
  input  logic [1:0]            i_resultsrc_e,
  input  logic                  i_memwrite_e,
  input  alu_op_t               i_aluctrl_e,
  input  logic                  i_alusrc_e,
  input  logic [2:0]            i_storetype_e,
  input  logic [DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [DATA_WIDTH-1:0] i_immext_e,
  input  logic [PC_WIDTH-1:0]   i_pc_e,
  input  logic [PC_WIDTH-1:0]   i_pc4_e,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic [1:0]            i_forward_a_e,
  input  logic [1:0]            i_forward_b_e,
  input  logic [DATA_WIDTH-1:0] i_result_w,
  output logic                  o_zero_e,
  output logic [PC_WIDTH-1:0]   o_pctarget_e,
  output logic                  o_regwrite_m,
  output logic [1:0]            o_resultsrc_m,
  output logic                  o_memwrite_m,
  output logic [2:0]            o_storetype_m,
  output logic [DATA_WIDTH-1:0] o_aluresult_m,
  output logic [DATA_WIDTH-1:0] o_writedata_m,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_m,
  output logic [PC_WIDTH-1:0]   o_pc4_m
);

  // EX/MEM register state
  logic                  regwrite_q,  regwrite_d;
  logic [1:0]            resultsrc_q, resultsrc_d;
  logic                  memwrite_q,  memwrite_d;
  logic [2:0]            storetype_q, storetype_d;
  logic [DATA_WIDTH-1:0] aluresult_q, aluresult_d;
  logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
  logic [PC_WIDTH-1:0]   pc4_q,       pc4_d;

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] alu_result;

  // Forward muxes. The MEM path reads the registered ALU result of the
  // previous instruction, so there is no combinational loop through the ALU.
  always_comb begin
    case (i_forward_a_e)
      FWD_WB:  src_a = i_result_w;
      FWD_MEM: src_a = aluresult_q;
      default: src_a = i_rs1_data_e;
    endcase
  end

  always_comb begin
    case (i_forward_b_e)
      FWD_WB:  fwd_b = i_result_w;
      FWD_MEM: fwd_b = aluresult_q;
      default: fwd_b = i_rs2_data_e;
    endcase
  end

  assign src_b = i_alusrc_e ? i_immext_e : fwd_b;

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i      (src_a),
    .b_i      (src_b),
    .op_i     (i_aluctrl_e),
    .result_o (alu_result)
  );

  assign o_zero_e     = (alu_result == '0);
  // Target is computed at PC width, so it wraps naturally.
  assign o_pctarget_e = i_pc_e + i_immext_e[PC_WIDTH-1:0];

  // Next-state: hold while the memory stage is stalled.
  always_comb begin
    regwrite_d  = regwrite_q;
    resultsrc_d = resultsrc_q;
    memwrite_d  = memwrite_q;
    storetype_d = storetype_q;
    aluresult_d = aluresult_q;
    writedata_d = writedata_q;
    rd_addr_d   = rd_addr_q;
    pc4_d       = pc4_q;
    if (!i_stall_m) begin
      regwrite_d  = i_regwrite_e;
      resultsrc_d = i_resultsrc_e;
      memwrite_d  = i_memwrite_e;
      storetype_d = i_storetype_e;
      aluresult_d = alu_result;
      writedata_d = fwd_b;
      rd_addr_d   = i_rd_addr_e;
      pc4_d       = i_pc4_e;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      memwrite_q  <= 1'b0;
      storetype_q <= ST_WORD;
      aluresult_q <= '0;
      writedata_q <= '0;
      rd_addr_q   <= '0;
      pc4_q       <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      memwrite_q  <= memwrite_d;
      storetype_q <= storetype_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      rd_addr_q   <= rd_addr_d;
      pc4_q       <= pc4_d;
    end
  end

  assign o_regwrite_m  = regwrite_q;
  assign o_resultsrc_m = resultsrc_q;
  assign o_memwrite_m  = memwrite_q;
  assign o_storetype_m = storetype_q;
  assign o_aluresult_m = aluresult_q;
  assign o_writedata_m = writedata_q;
  assign o_rd_addr_m   = rd_addr_q;
  assign o_pc4_m       = pc4_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Directed-vector bench for execute_stage; expected values are hand-computed.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall_m;
  logic        i_regwrite_e;
  logic [1:0]  i_resultsrc_e;
  logic        i_memwrite_e;
  alu_op_t     i_aluctrl_e;
  logic        i_alusrc_e;
  logic [2:0]  i_storetype_e;
  logic [31:0] i_rs1_data_e;
  logic [31:0] i_rs2_data_e;
  logic [31:0] i_immext_e;
  logic [10:0] i_pc_e;
  logic [10:0] i_pc4_e;
  logic [4:0]  i_rd_addr_e;
  logic [1:0]  i_forward_a_e;
  logic [1:0]  i_forward_b_e;
  logic [31:0] i_result_w;
  logic        o_zero_e;
  logic [10:0] o_pctarget_e;
  logic        o_regwrite_m;
  logic [1:0]  o_resultsrc_m;
  logic        o_memwrite_m;
  logic [2:0]  o_storetype_m;
  logic [31:0] o_aluresult_m;
  logic [31:0] o_writedata_m;
  logic [4:0]  o_rd_addr_m;
  logic [10:0] o_pc4_m;

  int n_checks = 0;
  int n_errors = 0;

  execute_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .PC_WIDTH   (11)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stall_m     (i_stall_m),
    .i_regwrite_e  (i_regwrite_e),
    .i_resultsrc_e (i_resultsrc_e),
    .i_memwrite_e  (i_memwrite_e),
    .i_aluctrl_e   (i_aluctrl_e),
    .i_alusrc_e    (i_alusrc_e),
    .i_storetype_e (i_storetype_e),
    .i_rs1_data_e  (i_rs1_data_e),
    .i_rs2_data_e  (i_rs2_data_e),
    .i_immext_e    (i_immext_e),
    .i_pc_e        (i_pc_e),
    .i_pc4_e       (i_pc4_e),
    .i_rd_addr_e   (i_rd_addr_e),
    .i_forward_a_e (i_forward_a_e),
    .i_forward_b_e (i_forward_b_e),
    .i_result_w    (i_result_w),
    .o_zero_e      (o_zero_e),
    .o_pctarget_e  (o_pctarget_e),
    .o_regwrite_m  (o_regwrite_m),
    .o_resultsrc_m (o_resultsrc_m),
    .o_memwrite_m  (o_memwrite_m),
    .o_storetype_m (o_storetype_m),
    .o_aluresult_m (o_aluresult_m),
    .o_writedata_m (o_writedata_m),
    .o_rd_addr_m   (o_rd_addr_m),
    .o_pc4_m       (o_pc4_m)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Load an ALU op with register/immediate operands, no forwarding.
  task automatic set_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_imm);
    i_aluctrl_e   = op;
    i_rs1_data_e  = a;
    i_alusrc_e    = use_imm;
    if (use_imm) i_immext_e = b;
    else i_rs2_data_e = b;
    i_forward_a_e = FWD_REG;
    i_forward_b_e = FWD_REG;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_stall_m     = 1'b0;
    i_regwrite_e  = 1'b0;
    i_resultsrc_e = 2'b00;
    i_memwrite_e  = 1'b0;
    i_aluctrl_e   = ALU_UNUSED;
    i_alusrc_e    = 1'b0;
    i_storetype_e = 3'b010;
    i_rs1_data_e  = '0;
    i_rs2_data_e  = '0;
    i_immext_e    = '0;
    i_pc_e        = '0;
    i_pc4_e       = '0;
    i_rd_addr_e   = '0;
    i_forward_a_e = FWD_REG;
    i_forward_b_e = FWD_REG;
    i_result_w    = '0;

    // Reset state
    #12;
    check("rst_aluresult", o_aluresult_m, 32'h0);
    check("rst_storetype", {29'b0, o_storetype_m}, 32'h2);
    check("rst_regwrite", {31'b0, o_regwrite_m}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // ADD with immediate: 0x10 + 0x5 -> 0x15, rd 3
    set_op(ALU_ADD, 32'h10, 32'h5, 1'b1);
    i_regwrite_e = 1'b1;
    i_rd_addr_e  = 5'd3;
    #1;
    check("add_zero_e", {31'b0, o_zero_e}, 32'h0);
    tick();
    check("add_aluresult", o_aluresult_m, 32'h15);
    check("add_rd", {27'b0, o_rd_addr_m}, 32'h3);
    check("add_regwrite", {31'b0, o_regwrite_m}, 32'h1);
    $display("txn ADD imm: aluresult=%h rd=%0d", o_aluresult_m, o_rd_addr_m);

    // SUB 5-5: zero flag in the same cycle
    set_op(ALU_SUB, 32'h5, 32'h5, 1'b1);
    #1;
    check("sub_zero_e", {31'b0, o_zero_e}, 32'h1);
    tick();
    check("sub_aluresult", o_aluresult_m, 32'h0);
    $display("txn SUB 5-5: zero=%0d", o_zero_e);

    // Prime o_aluresult_m = 0x100
    set_op(ALU_ADD, 32'h100, 32'h0, 1'b1);
    tick();
    check("prime_aluresult", o_aluresult_m, 32'h100);

    // Forwarding: A from MEM (0x100), B from WB (0x200)
    i_rs1_data_e  = 32'h1;
    i_rs2_data_e  = 32'h2;
    i_result_w    = 32'h200;
    i_alusrc_e    = 1'b0;
    i_forward_a_e = FWD_MEM;
    i_forward_b_e = FWD_WB;
    tick();
    check("fwd_aluresult", o_aluresult_m, 32'h300);
    check("fwd_writedata", o_writedata_m, 32'h200);
    $display("txn FWD mem+wb: aluresult=%h writedata=%h", o_aluresult_m, o_writedata_m);

    // Select 11 behaves as register
    i_forward_a_e = 2'b11;
    i_forward_b_e = FWD_REG;
    tick();
    check("fwd11_aluresult", o_aluresult_m, 32'h3);
    check("fwd11_writedata", o_writedata_m, 32'h2);
    $display("txn FWD reg: aluresult=%h", o_aluresult_m);

    // Signed / unsigned compares
    set_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1);
    tick();
    check("slt", o_aluresult_m, 32'h1);
    set_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b1);
    #1;
    check("sltu_zero_e", {31'b0, o_zero_e}, 32'h1);
    tick();
    check("sltu", o_aluresult_m, 32'h0);
    $display("txn SLT/SLTU: sltu=%h", o_aluresult_m);

    // Shifts
    set_op(ALU_SRA, 32'h8000_0000, 32'h4, 1'b1);
    tick();
    check("sra", o_aluresult_m, 32'hF800_0000);
    set_op(ALU_SRL, 32'h8000_0000, 32'h4, 1'b1);
    tick();
    check("srl", o_aluresult_m, 32'h0800_0000);
    set_op(ALU_SLL, 32'h0000_0003, 32'h24, 1'b1); // shamt uses b[4:0] = 4
    tick();
    check("sll", o_aluresult_m, 32'h0000_0030);
    $display("txn shifts: sll=%h", o_aluresult_m);

    // Logic ops via register operand (alusrc=0)
    set_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    tick();
    check("and", o_aluresult_m, 32'h00F0_1200);
    set_op(ALU_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    tick();
    check("or", o_aluresult_m, 32'hFFF0_FF34);
    set_op(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    tick();
    check("xor", o_aluresult_m, 32'hFF00_ED34);
    set_op(ALU_PASSB, 32'h1234_5678, 32'hABCD_E000, 1'b1);
    tick();
    check("passb", o_aluresult_m, 32'hABCD_E000);
    set_op(ALU_SUB, 32'h0, 32'h1, 1'b1);
    tick();
    check("sub_wrap", o_aluresult_m, 32'hFFFF_FFFF);
    set_op(alu_op_t'(4'd13), 32'h5, 32'h7, 1'b1);
    #1;
    check("undef_zero_e", {31'b0, o_zero_e}, 32'h1);
    tick();
    check("undef_op", o_aluresult_m, 32'h0);
    $display("txn logic/passb/undef: last=%h", o_aluresult_m);

    // Branch target wrap
    i_pc_e     = 11'h7FC;
    i_immext_e = 32'h8;
    #1;
    check("pctarget_wrap", {21'b0, o_pctarget_e}, 32'h004);
    i_pc_e     = 11'h010;
    i_immext_e = 32'hFFFF_FFF8;
    #1;
    check("pctarget_neg", {21'b0, o_pctarget_e}, 32'h008);
    $display("txn pctarget: %h", o_pctarget_e);

    // Known value, then stall
    set_op(ALU_ADD, 32'h11, 32'h22, 1'b1);
    i_regwrite_e  = 1'b1;
    i_memwrite_e  = 1'b1;
    i_resultsrc_e = 2'b01;
    i_storetype_e = 3'b000;
    i_rd_addr_e   = 5'd7;
    i_pc4_e       = 11'h123;
    tick();
    check("pre_stall_alu", o_aluresult_m, 32'h33);
    check("pre_stall_pc4", {21'b0, o_pc4_m}, 32'h123);
    check("pre_stall_storetype", {29'b0, o_storetype_m}, 32'h0);

    i_stall_m = 1'b1;
    set_op(ALU_SUB, 32'h9, 32'h9, 1'b1);
    i_regwrite_e  = 1'b0;
    i_memwrite_e  = 1'b0;
    i_resultsrc_e = 2'b10;
    i_storetype_e = 3'b001;
    i_rd_addr_e   = 5'd9;
    i_pc4_e       = 11'h456;
    #1;
    check("stall_zero_tracks", {31'b0, o_zero_e}, 32'h1);
    tick();
    check("stall1_alu", o_aluresult_m, 32'h33);
    check("stall1_rd", {27'b0, o_rd_addr_m}, 32'h7);
    i_pc4_e = 11'h457;
    tick();
    check("stall2_alu", o_aluresult_m, 32'h33);
    check("stall2_memwrite", {31'b0, o_memwrite_m}, 32'h1);
    check("stall2_pc4", {21'b0, o_pc4_m}, 32'h123);
    check("stall2_resultsrc", {30'b0, o_resultsrc_m}, 32'h1);
    $display("txn stall: held aluresult=%h", o_aluresult_m);

    // Release: captures current inputs
    i_stall_m = 1'b0;
    set_op(ALU_ADD, 32'h40, 32'h2, 1'b1);
    tick();
    check("release_alu", o_aluresult_m, 32'h42);
    check("release_rd", {27'b0, o_rd_addr_m}, 32'h9);
    check("release_pc4", {21'b0, o_pc4_m}, 32'h457);
    check("release_storetype", {29'b0, o_storetype_m}, 32'h1);
    check("release_resultsrc", {30'b0, o_resultsrc_m}, 32'h2);
    $display("txn release: aluresult=%h", o_aluresult_m);

    // Bubble
    i_regwrite_e = 1'b0;
    i_memwrite_e = 1'b0;
    set_op(ALU_UNUSED, 32'hDEAD_BEEF, 32'h1234, 1'b1);
    tick();
    check("bubble_alu", o_aluresult_m, 32'h0);
    check("bubble_regwrite", {31'b0, o_regwrite_m}, 32'h0);
    $display("txn bubble: aluresult=%h", o_aluresult_m);

    // Mid-stream asynchronous reset while stalled
    set_op(ALU_ADD, 32'h5, 32'h6, 1'b1);
    i_regwrite_e  = 1'b1;
    i_memwrite_e  = 1'b1;
    i_rd_addr_e   = 5'd4;
    i_forward_b_e = FWD_WB;
    tick();
    check("prerst_alu", o_aluresult_m, 32'hB);
    check("prerst_writedata", o_writedata_m, 32'h200);
    i_stall_m = 1'b1;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_alu", o_aluresult_m, 32'h0);
    check("arst_writedata", o_writedata_m, 32'h0);
    check("arst_regwrite", {31'b0, o_regwrite_m}, 32'h0);
    check("arst_memwrite", {31'b0, o_memwrite_m}, 32'h0);
    check("arst_rd", {27'b0, o_rd_addr_m}, 32'h0);
    check("arst_pc4", {21'b0, o_pc4_m}, 32'h0);
    check("arst_resultsrc", {30'b0, o_resultsrc_m}, 32'h0);
    check("arst_storetype", {29'b0, o_storetype_m}, 32'h2);
    $display("txn async reset: aluresult=%h storetype=%b", o_aluresult_m, o_storetype_m);
    @(negedge i_clk);
    i_rst_n   = 1'b1;
    i_stall_m = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
